vga_crtc: RTL and testbench
===========================

# vga_crtc

Parametrised CRT timing controller for the VDU family: generates horizontal/vertical sync, blanking, pixel and character-cell coordinates, and a blinking hardware cursor for any resolution, sync polarity and pixel-clock divide. It replaces fixed 640x480 timing with a generic core that a text or graphics VDU uses as its raster source. A small Wishbone slave programs the cursor; cursor registers are shadowed and applied at frame start, so moves never tear.

## Interface
Parameters:
- H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48: horizontal pixels per region
- V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: vertical lines per region
- HSYNC_POL 0, VSYNC_POL 0: active level of each sync
- CLK_DIV 1: wb_clk_i cycles per pixel (1..8)
- CHAR_W 8, CHAR_H 16: character cell size, powers of two
- BLINK_FRAMES 16: frames per blink half-period

Ports:
- wb_clk_i in 1: single clock
- wb_rst_i in 1: reset, asynchronous, active-low
- horiz_sync, vert_sync out 1: syncs at configured polarity
- blank_o out 1: 1 outside active area
- frame_start_o out 1: one-clock pulse at pixel (0,0)
- pix_x out clog2(H_ACTIVE+H_FP+H_SYNC+H_BP); pix_y out clog2(V total): raw counters
- char_col, char_row out 8: pix_x/CHAR_W, pix_y/CHAR_H
- glyph_x out clog2(CHAR_W); glyph_y out clog2(CHAR_H): position inside cell
- cursor_o out 1: current pixel is in a visible cursor
- wb_dat_i in 16, wb_adr_i in 2, wb_we_i, wb_stb_i, wb_cyc_i in 1
- wb_dat_o out 16, wb_ack_o out 1

## Operation
- Pixel enable: divider counter 0..CLK_DIV-1; pen=1 when it equals CLK_DIV-1 (always 1 for CLK_DIV=1).
- h_cnt 0..HT-1 (HT=sum of H params), advances on pen; at HT-1 wraps to 0 and v_cnt advances; v_cnt wraps at VT-1.
- Regions, by counter: active h_cnt<H_ACTIVE; hsync H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC; same pattern vertically. blank = ~(h_active & v_active).
- Registers (address): 0 cursor col [7:0]; 1 cursor row [7:0]; 2 control: bit0 cursor_en, bit1 blink_en, [7:4] cursor start scanline, [11:8] end scanline; 3 status read-only: bit0 = vertical blank, [15:8] frame count low byte. Reset: all 0. Writes to 3 ignored; unused bits read 0.
- Shadow copies of regs 0-2 load when counters wrap to (0,0) on pen.
- Frame counter increments at each frame wrap; blink phase toggles every BLINK_FRAMES frames, reset 0 (cursor visible phase = 1).
- cursor_o = cursor_en & (phase | ~blink_en) & active & col/row match & start ≤ glyph_y ≤ end. start>end: never visible.

## Timing
- All outputs registered: outputs reflect counter values with 1-clock latency, mutually aligned.
- Reset (wb_rst_i=0): counters, divider, frame count, registers, shadows 0; horiz_sync=~HSYNC_POL, vert_sync=~VSYNC_POL, blank_o=1, cursor_o=0, frame_start_o=0, coordinates 0, wb_ack_o=0, wb_dat_o=0. Reset mid-frame restarts at (0,0) immediately.
- First clock edge after release: outputs show (0,0), blank_o=0, frame_start_o=1.
- With CLK_DIV>1 outputs hold for CLK_DIV clocks; frame_start_o is 1 clock only.
- Wishbone: wb_ack_o = registered (stb & cyc & ~ack), one-clock pulse; single access per two clocks minimum. Write commits on the ack edge; read data valid with ack.
- Write landing on the same edge as shadow load: shadow takes the old value; new value applies next frame.

## Test plan
Small config: H 8/2/3/3 (HT=16), V 4/1/2/1 (VT=8), CHAR 4x2, CLK_DIV 1, BLINK_FRAMES 2, polarities 0.
- Reset released -> blank_o 0 for pix_x 0..7, 1 for 8..15; horiz_sync low exactly pix_x 10..12; period 16 clocks; vert_sync low lines 5..6; frame 128 clocks.
- Write col=1,row=1,ctrl=0x0101 mid-frame -> cursor_o 0 this frame; next frame high at pix_x 4..7, pix_y 2..3, 8 clocks total.
- blink_en set -> cursor visible frames 0-1, hidden 2-3 of enable; blink_en 0 -> every frame.
- Read addr 3 during line 5 -> bit0=1, ack one clock after stb; write to addr 3 leaves value unchanged.
- CLK_DIV=3 -> hsync width 9 clocks, line 48 clocks, frame_start_o 1-clock pulse.
- Assert reset at pix (5,2) -> outputs at reset values asynchronously; restart from (0,0); registers read 0.

Source files
------------

// File: rtl/vga_crtc.sv
// Parametrised CRT timing controller: sync/blank generation, pixel and character-cell
// coordinates, and a blinking hardware cursor programmed through a small Wishbone slave.
module vga_crtc #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter bit HSYNC_POL    = 1'b0,
    parameter bit VSYNC_POL    = 1'b0,
    parameter int CLK_DIV      = 1,
    parameter int CHAR_W       = 8,
    parameter int CHAR_H       = 16,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                                                  wb_clk_i,
    input  logic                                                  wb_rst_i,
    output logic                                                  horiz_sync,
    output logic                                                  vert_sync,
    output logic                                                  blank_o,
    output logic                                                  frame_start_o,
    output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]          pix_x,
    output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]          pix_y,
    output logic [7:0]                                            char_col,
    output logic [7:0]                                            char_row,
    output logic [$clog2(CHAR_W)-1:0]                             glyph_x,
    output logic [$clog2(CHAR_H)-1:0]                             glyph_y,
    output logic                                                  cursor_o,
    input  logic [15:0]                                           wb_dat_i,
    input  logic [1:0]                                            wb_adr_i,
    input  logic                                                  wb_we_i,
    input  logic                                                  wb_stb_i,
    input  logic                                                  wb_cyc_i,
    output logic [15:0]                                           wb_dat_o,
    output logic                                                  wb_ack_o
);

    localparam int HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW  = $clog2(HT);
    localparam int VW  = $clog2(VT);
    localparam int GXW = $clog2(CHAR_W);
    localparam int GYW = $clog2(CHAR_H);
    localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [31:0] HA  = 32'(H_ACTIVE);
    localparam logic [31:0] HSB = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] HSE = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] VA  = 32'(V_ACTIVE);
    localparam logic [31:0] VSB = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] VSE = 32'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0]  r_div;
    logic [HW-1:0]  r_h;
    logic [VW-1:0]  r_v;
    logic           w_pen;
    logic           w_h_last;
    logic           w_v_last;
    logic           w_wrap;

    assign w_pen    = (r_div == DW'(CLK_DIV - 1));
    assign w_h_last = (r_h == HW'(HT - 1));
    assign w_v_last = (r_v == VW'(VT - 1));
    assign w_wrap   = w_pen & w_h_last & w_v_last;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_div <= '0;
            r_h   <= '0;
            r_v   <= '0;
        end else begin
            r_div <= w_pen ? '0 : r_div + DW'(1);
            if (w_pen) begin
                if (w_h_last) begin
                    r_h <= '0;
                    r_v <= w_v_last ? '0 : r_v + VW'(1);
                end else begin
                    r_h <= r_h + HW'(1);
                end
            end
        end
    end

    logic [31:0]    w_hx;
    logic [31:0]    w_vx;
    logic           w_h_act;
    logic           w_v_act;
    logic           w_hs;
    logic           w_vs;
    logic [7:0]     w_col;
    logic [7:0]     w_row;
    logic [GYW-1:0] w_gy;

    assign w_hx    = 32'(r_h);
    assign w_vx    = 32'(r_v);
    assign w_h_act = (w_hx < HA);
    assign w_v_act = (w_vx < VA);
    assign w_hs    = (w_hx >= HSB) && (w_hx < HSE);
    assign w_vs    = (w_vx >= VSB) && (w_vx < VSE);
    assign w_col   = 8'(r_h >> GXW);
    assign w_row   = 8'(r_v >> GYW);
    assign w_gy    = r_v[GYW-1:0];

    // Programmed cursor registers and the per-frame shadow copies the raster uses
    logic [7:0]     r_cur_col;
    logic [7:0]     r_cur_row;
    logic           r_cen;
    logic           r_ben;
    logic [3:0]     r_cs;
    logic [3:0]     r_ce;
    logic [7:0]     r_sh_col;
    logic [7:0]     r_sh_row;
    logic           r_sh_cen;
    logic           r_sh_ben;
    logic [3:0]     r_sh_cs;
    logic [3:0]     r_sh_ce;
    logic [7:0]     r_frame;
    logic [BW-1:0]  r_bcnt;
    logic           r_phase;
    logic           r_ack;
    logic [15:0]    r_dat;
    logic [15:0]    w_rdata;
    logic           w_acc;
    logic           w_unused;

    assign w_acc    = wb_stb_i & wb_cyc_i & ~r_ack;
    assign w_unused = &{1'b0, wb_dat_i[15:12], wb_dat_i[3:2]};

    always_comb begin
        w_rdata = '0;
        case (wb_adr_i)
            2'd0:    w_rdata = {8'h00, r_cur_col};
            2'd1:    w_rdata = {8'h00, r_cur_row};
            2'd2:    w_rdata = {4'h0, r_ce, r_cs, 2'b00, r_ben, r_cen};
            default: w_rdata = {r_frame, 7'h00, ~w_v_act};
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_ack     <= 1'b0;
            r_dat     <= '0;
            r_cur_col <= '0;
            r_cur_row <= '0;
            r_cen     <= 1'b0;
            r_ben     <= 1'b0;
            r_cs      <= '0;
            r_ce      <= '0;
        end else begin
            r_ack <= w_acc;
            r_dat <= (w_acc & ~wb_we_i) ? w_rdata : '0;
            if (w_acc & wb_we_i) begin
                case (wb_adr_i)
                    2'd0: r_cur_col <= wb_dat_i[7:0];
                    2'd1: r_cur_row <= wb_dat_i[7:0];
                    2'd2: begin
                        r_cen <= wb_dat_i[0];
                        r_ben <= wb_dat_i[1];
                        r_cs  <= wb_dat_i[7:4];
                        r_ce  <= wb_dat_i[11:8];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Blink runs only while blinking is in effect; otherwise it parks at the visible
    // phase so a newly enabled blink always starts with the cursor shown.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_sh_col <= '0;
            r_sh_row <= '0;
            r_sh_cen <= 1'b0;
            r_sh_ben <= 1'b0;
            r_sh_cs  <= '0;
            r_sh_ce  <= '0;
            r_frame  <= '0;
            r_bcnt   <= '0;
            r_phase  <= 1'b0;
        end else if (w_wrap) begin
            r_sh_col <= r_cur_col;
            r_sh_row <= r_cur_row;
            r_sh_cen <= r_cen;
            r_sh_ben <= r_ben;
            r_sh_cs  <= r_cs;
            r_sh_ce  <= r_ce;
            r_frame  <= r_frame + 8'd1;
            if (!r_sh_ben) begin
                r_bcnt  <= '0;
                r_phase <= 1'b1;
            end else if (r_bcnt == BW'(BLINK_FRAMES - 1)) begin
                r_bcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_bcnt  <= r_bcnt + BW'(1);
            end
        end
    end

    logic w_cur;
    assign w_cur = r_sh_cen & (r_phase | ~r_sh_ben) & w_h_act & w_v_act
                 & (w_col == r_sh_col) & (w_row == r_sh_row)
                 & (32'(w_gy) >= 32'(r_sh_cs)) & (32'(w_gy) <= 32'(r_sh_ce));

    // Output register stage: every raster output lags the counters by one clock
    logic            r_hs;
    logic            r_vs;
    logic            r_blank;
    logic            r_fs;
    logic [HW-1:0]   r_px;
    logic [VW-1:0]   r_py;
    logic [7:0]      r_ccol;
    logic [7:0]      r_crow;
    logic [GXW-1:0]  r_gx;
    logic [GYW-1:0]  r_gy;
    logic            r_cursor;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_hs     <= ~HSYNC_POL;
            r_vs     <= ~VSYNC_POL;
            r_blank  <= 1'b1;
            r_fs     <= 1'b0;
            r_px     <= '0;
            r_py     <= '0;
            r_ccol   <= '0;
            r_crow   <= '0;
            r_gx     <= '0;
            r_gy     <= '0;
            r_cursor <= 1'b0;
        end else begin
            r_hs     <= w_hs ? HSYNC_POL : ~HSYNC_POL;
            r_vs     <= w_vs ? VSYNC_POL : ~VSYNC_POL;
            r_blank  <= ~(w_h_act & w_v_act);
            r_fs     <= (r_h == '0) && (r_v == '0) && (r_div == '0);
            r_px     <= r_h;
            r_py     <= r_v;
            r_ccol   <= w_col;
            r_crow   <= w_row;
            r_gx     <= r_h[GXW-1:0];
            r_gy     <= w_gy;
            r_cursor <= w_cur;
        end
    end

    assign horiz_sync    = r_hs;
    assign vert_sync     = r_vs;
    assign blank_o       = r_blank;
    assign frame_start_o = r_fs;
    assign pix_x         = r_px;
    assign pix_y         = r_py;
    assign char_col      = r_ccol;
    assign char_row      = r_crow;
    assign glyph_x       = r_gx;
    assign glyph_y       = r_gy;
    assign cursor_o      = r_cursor;
    assign wb_dat_o      = r_dat;
    assign wb_ack_o      = r_ack;

endmodule

// File: tb/tb_vga_crtc.sv
// Directed bench for vga_crtc in a tiny 16x8 raster (4x2 cells), with a second
// instance at a pixel divide of 3 to check clock-enabled timing.
module tb_vga_crtc;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] dat_i = '0;
    logic [1:0]  adr   = '0;
    logic        we    = 1'b0;
    logic        stb   = 1'b0;
    logic        cyc   = 1'b0;

    logic        hs, vs, blank, fs, cur, ack;
    logic [3:0]  px;
    logic [2:0]  py;
    logic [7:0]  col, row;
    logic [1:0]  gx;
    logic [0:0]  gy;
    logic [15:0] dat_o;

    logic        hs3, vs3, blank3, fs3, cur3, ack3;
    logic [3:0]  px3;
    logic [2:0]  py3;
    logic [7:0]  col3, row3;
    logic [1:0]  gx3;
    logic [0:0]  gy3;
    logic [15:0] dat3;

    vga_crtc #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(1),
        .CHAR_W(4), .CHAR_H(2), .BLINK_FRAMES(2)
    ) u_dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .horiz_sync(hs), .vert_sync(vs), .blank_o(blank), .frame_start_o(fs),
        .pix_x(px), .pix_y(py), .char_col(col), .char_row(row),
        .glyph_x(gx), .glyph_y(gy), .cursor_o(cur),
        .wb_dat_i(dat_i), .wb_adr_i(adr), .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc),
        .wb_dat_o(dat_o), .wb_ack_o(ack)
    );

    vga_crtc #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(3),
        .CHAR_W(4), .CHAR_H(2), .BLINK_FRAMES(2)
    ) u_div3 (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .horiz_sync(hs3), .vert_sync(vs3), .blank_o(blank3), .frame_start_o(fs3),
        .pix_x(px3), .pix_y(py3), .char_col(col3), .char_row(row3),
        .glyph_x(gx3), .glyph_y(gy3), .cursor_o(cur3),
        .wb_dat_i(16'h0000), .wb_adr_i(2'b00), .wb_we_i(1'b0), .wb_stb_i(1'b0), .wb_cyc_i(1'b0),
        .wb_dat_o(dat3), .wb_ack_o(ack3)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int cyc; int x; int y; int bl; int hs; int vs; int fs;
        int col; int row; int gx; int gy;
    } vec_t;
    vec_t tv[16];

    int s_px[401], s_py[401], s_bl[401], s_hs[401], s_vs[401], s_fs[401];
    int s_col[401], s_row[401], s_gx[401], s_gy[401];
    int s3_hs[401], s3_fs[401], s3_px[401], s3_py[401];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pix(input int x, input int y);
        int n;
        n = 0;
        step();
        while (!(int'(px) == x && int'(py) == y) && n < 400) begin
            step();
            n++;
        end
        if (!(int'(px) == x && int'(py) == y)) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_pix(%0d,%0d): not reached within %0d clocks", x, y, n);
        end
    endtask

    task automatic count_until_fs(output int cnt);
        int n;
        n   = 0;
        cnt = 0;
        step();
        while (fs !== 1'b1 && n < 400) begin
            cnt += int'(cur);
            step();
            n++;
        end
        if (fs !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL frame_start: not seen within %0d clocks", n);
        end
    endtask

    task automatic frame_from_here(output int cnt, output int bad);
        cnt = 0;
        bad = 0;
        for (int i = 0; i < 128; i++) begin
            if (i != 0) step();
            if (cur === 1'b1) begin
                cnt++;
                if (!(px >= 4 && px <= 7 && py >= 2 && py <= 3)) bad++;
            end
        end
    endtask

    task automatic measure_frame(output int cnt, output int bad);
        int skip;
        count_until_fs(skip);
        frame_from_here(cnt, bad);
    endtask

    task automatic wb_write(input int a, input int d);
        @(negedge clk);
        adr = a[1:0]; dat_i = d[15:0]; we = 1'b1; stb = 1'b1; cyc = 1'b1;
        step();
        chk("wr_ack_rise", int'(ack), 1);
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        step();
        chk("wr_ack_fall", int'(ack), 0);
    endtask

    task automatic wb_read(input int a, output int d);
        @(negedge clk);
        chk("rd_ack_idle", int'(ack), 0);
        adr = a[1:0]; we = 1'b0; stb = 1'b1; cyc = 1'b1;
        step();
        chk("rd_ack_rise", int'(ack), 1);
        d = int'(dat_o);
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0;
        step();
        chk("rd_ack_fall", int'(ack), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, bad, rd, first_low, last_low, lows, fcount;
        int exp_blink[5];

        //          cyc  x  y bl hs vs fs col row gx gy
        tv[0]  = '{  1,  0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
        tv[1]  = '{  8,  7, 0, 0, 1, 1, 0, 1, 0, 3, 0};
        tv[2]  = '{  9,  8, 0, 1, 1, 1, 0, 2, 0, 0, 0};
        tv[3]  = '{ 11, 10, 0, 1, 0, 1, 0, 2, 0, 2, 0};
        tv[4]  = '{ 13, 12, 0, 1, 0, 1, 0, 3, 0, 0, 0};
        tv[5]  = '{ 14, 13, 0, 1, 1, 1, 0, 3, 0, 1, 0};
        tv[6]  = '{ 16, 15, 0, 1, 1, 1, 0, 3, 0, 3, 0};
        tv[7]  = '{ 17,  0, 1, 0, 1, 1, 0, 0, 0, 0, 1};
        tv[8]  = '{ 40,  7, 2, 0, 1, 1, 0, 1, 1, 3, 0};
        tv[9]  = '{ 56,  7, 3, 0, 1, 1, 0, 1, 1, 3, 1};
        tv[10] = '{ 65,  0, 4, 1, 1, 1, 0, 0, 2, 0, 0};
        tv[11] = '{ 81,  0, 5, 1, 1, 0, 0, 0, 2, 0, 1};
        tv[12] = '{ 97,  0, 6, 1, 1, 0, 0, 0, 3, 0, 0};
        tv[13] = '{113,  0, 7, 1, 1, 1, 0, 0, 3, 0, 1};
        tv[14] = '{128, 15, 7, 1, 1, 1, 0, 3, 3, 3, 1};
        tv[15] = '{129,  0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
        exp_blink = '{8, 8, 0, 0, 8};

        // Reset state
        #23;
        chk("rst_hs", int'(hs), 1);
        chk("rst_vs", int'(vs), 1);
        chk("rst_blank", int'(blank), 1);
        chk("rst_fs", int'(fs), 0);
        chk("rst_cursor", int'(cur), 0);
        chk("rst_px", int'(px), 0);
        chk("rst_py", int'(py), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_dat", int'(dat_o), 0);
        chk("rst_hs3", int'(hs3), 1);
        chk("rst_blank3", int'(blank3), 1);
        chk("rst_fs3", int'(fs3), 0);

        // Record the raster after release
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            step();
            s_px[k] = int'(px);   s_py[k] = int'(py);   s_bl[k] = int'(blank);
            s_hs[k] = int'(hs);   s_vs[k] = int'(vs);   s_fs[k] = int'(fs);
            s_col[k] = int'(col); s_row[k] = int'(row); s_gx[k] = int'(gx); s_gy[k] = int'(gy);
            s3_hs[k] = int'(hs3); s3_fs[k] = int'(fs3); s3_px[k] = int'(px3); s3_py[k] = int'(py3);
        end

        for (int i = 0; i < 16; i++) begin
            c = tv[i].cyc;
            chk($sformatf("vec%0d_px", i), s_px[c], tv[i].x);
            chk($sformatf("vec%0d_py", i), s_py[c], tv[i].y);
            chk($sformatf("vec%0d_blank", i), s_bl[c], tv[i].bl);
            chk($sformatf("vec%0d_hsync", i), s_hs[c], tv[i].hs);
            chk($sformatf("vec%0d_vsync", i), s_vs[c], tv[i].vs);
            chk($sformatf("vec%0d_fstart", i), s_fs[c], tv[i].fs);
            chk($sformatf("vec%0d_col", i), s_col[c], tv[i].col);
            chk($sformatf("vec%0d_row", i), s_row[c], tv[i].row);
            chk($sformatf("vec%0d_gx", i), s_gx[c], tv[i].gx);
            chk($sformatf("vec%0d_gy", i), s_gy[c], tv[i].gy);
        end

        for (int k = 1; k <= 256; k++) begin
            int h, v;
            h = (k - 1) % 16;
            v = ((k - 1) / 16) % 8;
            chk($sformatf("scan%0d_px", k), s_px[k], h);
            chk($sformatf("scan%0d_py", k), s_py[k], v);
            chk($sformatf("scan%0d_blank", k), s_bl[k], (h < 8 && v < 4) ? 0 : 1);
            chk($sformatf("scan%0d_hsync", k), s_hs[k], (h >= 10 && h < 13) ? 0 : 1);
            chk($sformatf("scan%0d_vsync", k), s_vs[k], (v >= 5 && v < 7) ? 0 : 1);
            chk($sformatf("scan%0d_fstart", k), s_fs[k], (h == 0 && v == 0) ? 1 : 0);
        end

        // Divide-by-3 instance
        chk("div3_fs_c1", s3_fs[1], 1);
        chk("div3_fs_c2", s3_fs[2], 0);
        chk("div3_fs_c3", s3_fs[3], 0);
        chk("div3_fs_c385", s3_fs[385], 1);
        fcount = 0;
        for (int k = 1; k <= 384; k++) fcount += s3_fs[k];
        chk("div3_fs_per_frame", fcount, 1);
        lows = 0; first_low = 0; last_low = 0;
        for (int k = 1; k <= 48; k++) begin
            if (s3_hs[k] == 0) begin
                lows++;
                if (first_low == 0) first_low = k;
                last_low = k;
            end
        end
        chk("div3_hsync_width", lows, 9);
        chk("div3_hsync_first", first_low, 31);
        chk("div3_hsync_last", last_low, 39);
        chk("div3_px_c3", s3_px[3], 0);
        chk("div3_px_c4", s3_px[4], 1);
        chk("div3_px_c48", s3_px[48], 15);
        chk("div3_px_c49", s3_px[49], 0);
        chk("div3_py_c49", s3_py[49], 1);

        // Cursor programmed mid-frame appears only from the next frame
        wait_pix(0, 1);
        wb_write(0, 16'h0001);
        wb_write(1, 16'h0001);
        wb_write(2, 16'h0101);
        count_until_fs(c);
        chk("cursor_same_frame", c, 0);
        frame_from_here(c, bad);
        chk("cursor_next_frame_count", c, 8);
        chk("cursor_next_frame_pos", bad, 0);

        // Blink: shown two frames, hidden two, shown again
        wait_pix(0, 1);
        wb_write(2, 16'h0103);
        for (int f = 0; f < 5; f++) begin
            measure_frame(c, bad);
            chk($sformatf("blink_frame%0d", f), c, exp_blink[f]);
            chk($sformatf("blink_frame%0d_pos", f), bad, 0);
        end
        wait_pix(0, 1);
        wb_write(2, 16'h0101);
        for (int f = 0; f < 2; f++) begin
            measure_frame(c, bad);
            chk($sformatf("noblink_frame%0d", f), c, 8);
        end

        // Register readback and unused bits
        wb_read(0, rd);  chk("rd_col", rd, 16'h0001);
        wb_read(1, rd);  chk("rd_row", rd, 16'h0001);
        wb_read(2, rd);  chk("rd_ctrl", rd, 16'h0101);
        wb_write(2, 16'hFFFF);
        wb_read(2, rd);  chk("rd_ctrl_unused", rd, 16'h0FF3);
        wb_write(0, 16'hFFFF);
        wb_read(0, rd);  chk("rd_col_unused", rd, 16'h00FF);
        wb_write(0, 16'h0001);
        wb_write(2, 16'h0101);

        // Asynchronous reset in the middle of the cursor cell
        count_until_fs(c);
        wait_pix(5, 2);
        chk("cursor_before_reset", int'(cur), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_hs", int'(hs), 1);
        chk("arst_vs", int'(vs), 1);
        chk("arst_blank", int'(blank), 1);
        chk("arst_cursor", int'(cur), 0);
        chk("arst_fs", int'(fs), 0);
        chk("arst_px", int'(px), 0);
        chk("arst_py", int'(py), 0);
        chk("arst_col", int'(col), 0);
        chk("arst_row", int'(row), 0);
        chk("arst_ack", int'(ack), 0);
        chk("arst_dat", int'(dat_o), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("restart_px", int'(px), 0);
        chk("restart_py", int'(py), 0);
        chk("restart_fs", int'(fs), 1);
        chk("restart_blank", int'(blank), 0);
        chk("restart_hs", int'(hs), 1);
        wb_read(0, rd);  chk("rst_reg_col", rd, 0);
        wb_read(1, rd);  chk("rst_reg_row", rd, 0);
        wb_read(2, rd);  chk("rst_reg_ctrl", rd, 0);

        // Status: vertical blank flag and frame count
        wait_pix(0, 5);
        wb_read(3, rd);  chk("status_f0_line5", rd, 16'h0001);
        wait_pix(0, 1);
        wb_read(3, rd);  chk("status_f1_line1", rd, 16'h0100);
        wb_write(3, 16'hFFFF);
        wb_read(3, rd);  chk("status_after_write", rd, 16'h0100);
        wait_pix(0, 5);
        wb_read(3, rd);  chk("status_f1_line5", rd, 16'h0101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
